// File: rtl/ahb_pkg.sv
// Shared AHB frontend definitions: transfer types, frontend FSM states,
// register indices, error codes and the registered address-phase payload.
package ahb_pkg;

    localparam int unsigned HTRANS_W   = 2;
    localparam int unsigned HSIZE_W    = 3;
    localparam int unsigned DATA_W     = 8;
    localparam int unsigned REG_IDX_W  = 2;
    localparam int unsigned ERR_W      = 2;
    localparam int unsigned SIZE_REG_W = 5;

    typedef enum logic [HTRANS_W-1:0] {
        HTRANS_IDLE   = 2'd0,
        HTRANS_BUSY   = 2'd1,
        HTRANS_NONSEQ = 2'd2,
        HTRANS_SEQ    = 2'd3
    } htrans_e;

    typedef enum logic [1:0] {
        FE_IDLE = 2'd0,
        FE_DATA = 2'd1,
        FE_ERR1 = 2'd2,
        FE_ERR2 = 2'd3
    } fe_state_e;

    localparam logic [REG_IDX_W-1:0] REG_STATUS    = 2'd0;
    localparam logic [REG_IDX_W-1:0] REG_PAYLOAD_0 = 2'd1;
    localparam logic [REG_IDX_W-1:0] REG_PAYLOAD_1 = 2'd2;
    localparam logic [REG_IDX_W-1:0] REG_DATA_SIZE = 2'd3;

    localparam logic [ERR_W-1:0] ERR_NONE = 2'b00;
    localparam logic [ERR_W-1:0] ERR_ADDR = 2'b01;
    localparam logic [ERR_W-1:0] ERR_SIZE = 2'b10;
    localparam logic [ERR_W-1:0] ERR_RO   = 2'b11;

    // Address-phase information carried into the data phase
    typedef struct packed {
        logic [REG_IDX_W-1:0] idx;
        logic                 write;
    } addr_phase_t;

    // Prioritised error classification of an accepted transfer
    function automatic logic [ERR_W-1:0] classify_err(
        input logic                 addr_hi_nz,
        input logic [HSIZE_W-1:0]   size,
        input logic                 write,
        input logic [REG_IDX_W-1:0] idx
    );
        if (addr_hi_nz)                       return ERR_ADDR;
        else if (size != '0)                  return ERR_SIZE;
        else if (write && idx == REG_STATUS)  return ERR_RO;
        else                                  return ERR_NONE;
    endfunction

endpackage

// File: rtl/ahb_reg_bank.sv
// Register bank: one write port and the three writable registers.
//   hclk, hreset_n : clock, async active-low reset
//   we, widx, wdata: write strobe, register index, write data
//   payload_0/1    : 8-bit payload registers
//   data_size      : 5-bit size register (low bits of write data)
module ahb_reg_bank
    import ahb_pkg::*;
(
    input  logic                  hclk,
    input  logic                  hreset_n,
    input  logic                  we,
    input  logic [REG_IDX_W-1:0]  widx,
    input  logic [DATA_W-1:0]     wdata,
    output logic [DATA_W-1:0]     payload_0,
    output logic [DATA_W-1:0]     payload_1,
    output logic [SIZE_REG_W-1:0] data_size
);

    // Status index is read-only and falls through to no write
    always_ff @(posedge hclk or negedge hreset_n) begin
        if (!hreset_n) begin
            payload_0 <= '0;
            payload_1 <= '0;
            data_size <= '0;
        end else if (we) begin
            case (widx)
                REG_PAYLOAD_0: payload_0 <= wdata;
                REG_PAYLOAD_1: payload_1 <= wdata;
                REG_DATA_SIZE: data_size <= wdata[SIZE_REG_W-1:0];
                default:       ;
            endcase
        end
    end

endmodule

// File: rtl/ahb_slave_frontend.sv
// AHB slave frontend: accepts transfers, classifies errors, runs the
// two-cycle ERROR response and commits clean writes to the register bank.
//   hclk, hreset_n        : clock, async active-low reset
//   hsel_x, haddr, htrans,
//   hwrite, hsize, hready : address-phase inputs
//   hwdata                : data-phase write data
//   read_select           : register index of the current data phase
//   err_status            : sticky last error code
//   payload_0/1, data_size: register bank contents
//   current_hresp         : 1 = ERROR response this data phase
//   hready_fe             : 0 inserts a wait state
module ahb_slave_frontend
    import ahb_pkg::*;
#(
    parameter int unsigned ADDR_W = 8
) (
    input  logic                  hclk,
    input  logic                  hreset_n,
    input  logic                  hsel_x,
    input  logic [ADDR_W-1:0]     haddr,
    input  logic [HTRANS_W-1:0]   htrans,
    input  logic                  hwrite,
    input  logic [HSIZE_W-1:0]    hsize,
    input  logic [DATA_W-1:0]     hwdata,
    input  logic                  hready,
    output logic [REG_IDX_W-1:0]  read_select,
    output logic [ERR_W-1:0]      err_status,
    output logic [DATA_W-1:0]     payload_0,
    output logic [DATA_W-1:0]     payload_1,
    output logic [SIZE_REG_W-1:0] data_size,
    output logic                  current_hresp,
    output logic                  hready_fe
);

    if (ADDR_W < 3) begin : g_addr_w_check
        $error("ahb_slave_frontend: ADDR_W must be at least 3");
    end

    fe_state_e   state;
    addr_phase_t phase_q;

    htrans_e          trans_c;
    logic             accept_c;
    logic [ERR_W-1:0] err_c;
    logic             bank_we_c;
    logic             status_read_done_c;

    // ERR1 is excluded explicitly so a misbehaving bus hready cannot sneak in
    assign trans_c  = htrans_e'(htrans);
    assign accept_c = hsel_x && hready && (state != FE_ERR1)
                      && (trans_c == HTRANS_NONSEQ || trans_c == HTRANS_SEQ);
    assign err_c    = classify_err(haddr[ADDR_W-1:2] != '0, hsize, hwrite,
                                   haddr[REG_IDX_W-1:0]);

    // DATA is only ever entered by a clean accept, so its end commits the write
    assign bank_we_c          = (state == FE_DATA) && phase_q.write;
    assign status_read_done_c = (state == FE_DATA) && !phase_q.write
                                && (phase_q.idx == REG_STATUS);

    assign read_select = phase_q.idx;

    // Frontend FSM with registered response outputs
    always_ff @(posedge hclk or negedge hreset_n) begin
        if (!hreset_n) begin
            state         <= FE_IDLE;
            current_hresp <= 1'b0;
            hready_fe     <= 1'b1;
        end else begin
            case (state)
                FE_ERR1: begin
                    state         <= FE_ERR2;
                    current_hresp <= 1'b1;
                    hready_fe     <= 1'b1;
                end
                default: begin
                    if (accept_c && err_c != ERR_NONE) begin
                        state         <= FE_ERR1;
                        current_hresp <= 1'b1;
                        hready_fe     <= 1'b0;
                    end else if (accept_c) begin
                        state         <= FE_DATA;
                        current_hresp <= 1'b0;
                        hready_fe     <= 1'b1;
                    end else begin
                        state         <= FE_IDLE;
                        current_hresp <= 1'b0;
                        hready_fe     <= 1'b1;
                    end
                end
            endcase
        end
    end

    // Address-phase capture and sticky error status (new error beats clear)
    always_ff @(posedge hclk or negedge hreset_n) begin
        if (!hreset_n) begin
            phase_q    <= '0;
            err_status <= ERR_NONE;
        end else begin
            if (accept_c) begin
                phase_q.idx   <= haddr[REG_IDX_W-1:0];
                phase_q.write <= hwrite;
            end
            if (accept_c && err_c != ERR_NONE) begin
                err_status <= err_c;
            end else if (status_read_done_c) begin
                err_status <= ERR_NONE;
            end
        end
    end

    ahb_reg_bank u_reg_bank (
        .hclk      (hclk),
        .hreset_n  (hreset_n),
        .we        (bank_we_c),
        .widx      (phase_q.idx),
        .wdata     (hwdata),
        .payload_0 (payload_0),
        .payload_1 (payload_1),
        .data_size (data_size)
    );

endmodule

// File: tb/tb_ahb_slave_frontend.sv
// Directed self-checking bench for ahb_slave_frontend.
module tb_ahb_slave_frontend;

    logic       hclk = 1'b0;
    logic       hreset_n;
    logic       hsel_x;
    logic [7:0] haddr;
    logic [1:0] htrans;
    logic       hwrite;
    logic [2:0] hsize;
    logic [7:0] hwdata;
    logic       hready;
    logic       hready_drv;
    logic [1:0] read_select;
    logic [1:0] err_status;
    logic [7:0] payload_0;
    logic [7:0] payload_1;
    logic [4:0] data_size;
    logic       current_hresp;
    logic       hready_fe;

    int passed = 0;
    int total  = 0;

    // Single-slave bus: the slave's own ready closes the loop
    assign hready = hready_fe & hready_drv;

    always #5 hclk = ~hclk;

    ahb_slave_frontend #(.ADDR_W(8)) dut (
        .hclk          (hclk),
        .hreset_n      (hreset_n),
        .hsel_x        (hsel_x),
        .haddr         (haddr),
        .htrans        (htrans),
        .hwrite        (hwrite),
        .hsize         (hsize),
        .hwdata        (hwdata),
        .hready        (hready),
        .read_select   (read_select),
        .err_status    (err_status),
        .payload_0     (payload_0),
        .payload_1     (payload_1),
        .data_size     (data_size),
        .current_hresp (current_hresp),
        .hready_fe     (hready_fe)
    );

    task automatic tick();
        @(posedge hclk);
        #1;
    endtask

    task automatic addr_phase(input logic [1:0] tr, input logic [7:0] a,
                              input logic w, input logic [2:0] s);
        hsel_x = 1'b1;
        htrans = tr;
        haddr  = a;
        hwrite = w;
        hsize  = s;
    endtask

    task automatic idle_phase();
        hsel_x = 1'b0;
        htrans = 2'd0;
        haddr  = 8'h00;
        hwrite = 1'b0;
        hsize  = 3'd0;
    endtask

    task automatic test_reset();
        hreset_n   = 1'b0;
        hready_drv = 1'b1;
        hwdata     = 8'h00;
        idle_phase();
        repeat (2) @(posedge hclk);
        #1;
        total++; if (read_select !== 2'd0) $display("FAIL rst_read_select got=%0h exp=0", read_select); else passed++;
        total++; if (err_status !== 2'd0) $display("FAIL rst_err_status got=%0h exp=0", err_status); else passed++;
        total++; if (payload_0 !== 8'h00) $display("FAIL rst_payload_0 got=%0h exp=0", payload_0); else passed++;
        total++; if (payload_1 !== 8'h00) $display("FAIL rst_payload_1 got=%0h exp=0", payload_1); else passed++;
        total++; if (data_size !== 5'h00) $display("FAIL rst_data_size got=%0h exp=0", data_size); else passed++;
        total++; if (current_hresp !== 1'b0) $display("FAIL rst_hresp got=%0b exp=0", current_hresp); else passed++;
        total++; if (hready_fe !== 1'b1) $display("FAIL rst_hready_fe got=%0b exp=1", hready_fe); else passed++;
        @(negedge hclk);
        hreset_n = 1'b1;
        tick();
    endtask

    task automatic test_write_payload0();
        addr_phase(2'd2, 8'h01, 1'b1, 3'd0);
        tick();
        total++; if (current_hresp !== 1'b0) $display("FAIL wr0_hresp got=%0b exp=0", current_hresp); else passed++;
        total++; if (hready_fe !== 1'b1) $display("FAIL wr0_hready_fe got=%0b exp=1", hready_fe); else passed++;
        hwdata = 8'hA5;
        idle_phase();
        tick();
        total++; if (payload_0 !== 8'hA5) $display("FAIL wr0_payload_0 got=%0h exp=a5", payload_0); else passed++;
        total++; if (payload_1 !== 8'h00) $display("FAIL wr0_payload_1 got=%0h exp=0", payload_1); else passed++;
    endtask

    task automatic test_size_reg();
        addr_phase(2'd2, 8'h03, 1'b1, 3'd0);
        tick();
        hwdata = 8'hFF;
        addr_phase(2'd3, 8'h03, 1'b0, 3'd0);
        tick();
        total++; if (data_size !== 5'h1F) $display("FAIL size_data_size got=%0h exp=1f", data_size); else passed++;
        total++; if (read_select !== 2'd3) $display("FAIL size_read_select got=%0h exp=3", read_select); else passed++;
        total++; if (current_hresp !== 1'b0) $display("FAIL size_hresp got=%0b exp=0", current_hresp); else passed++;
        idle_phase();
        tick();
    endtask

    task automatic test_addr_error();
        addr_phase(2'd2, 8'h11, 1'b1, 3'd0);
        tick();
        total++; if (current_hresp !== 1'b1) $display("FAIL aerr_err1_hresp got=%0b exp=1", current_hresp); else passed++;
        total++; if (hready_fe !== 1'b0) $display("FAIL aerr_err1_hready_fe got=%0b exp=0", hready_fe); else passed++;
        total++; if (err_status !== 2'b01) $display("FAIL aerr_err_status got=%0h exp=1", err_status); else passed++;
        // Held request during the wait state must not be taken
        hwdata = 8'h33;
        addr_phase(2'd2, 8'h02, 1'b1, 3'd0);
        tick();
        total++; if (current_hresp !== 1'b1) $display("FAIL aerr_err2_hresp got=%0b exp=1", current_hresp); else passed++;
        total++; if (hready_fe !== 1'b1) $display("FAIL aerr_err2_hready_fe got=%0b exp=1", hready_fe); else passed++;
        total++; if (read_select !== 2'd1) $display("FAIL aerr_no_accept_err1 got=%0h exp=1", read_select); else passed++;
        idle_phase();
        tick();
        total++; if (current_hresp !== 1'b0) $display("FAIL aerr_idle_hresp got=%0b exp=0", current_hresp); else passed++;
        total++; if (payload_0 !== 8'hA5) $display("FAIL aerr_payload_0 got=%0h exp=a5", payload_0); else passed++;
        total++; if (payload_1 !== 8'h00) $display("FAIL aerr_payload_1 got=%0h exp=0", payload_1); else passed++;
        total++; if (err_status !== 2'b01) $display("FAIL aerr_sticky got=%0h exp=1", err_status); else passed++;
    endtask

    task automatic test_size_err_then_status_read();
        addr_phase(2'd2, 8'h02, 1'b1, 3'd1);
        tick();
        total++; if (err_status !== 2'b10) $display("FAIL serr_err_status got=%0h exp=2", err_status); else passed++;
        hwdata = 8'h5A;
        idle_phase();
        tick();
        // New transfer issued in ERR2
        addr_phase(2'd2, 8'h00, 1'b0, 3'd0);
        tick();
        total++; if (err_status !== 2'b10) $display("FAIL serr_during_read got=%0h exp=2", err_status); else passed++;
        total++; if (current_hresp !== 1'b0) $display("FAIL serr_read_hresp got=%0b exp=0", current_hresp); else passed++;
        total++; if (read_select !== 2'd0) $display("FAIL serr_read_select got=%0h exp=0", read_select); else passed++;
        total++; if (payload_1 !== 8'h00) $display("FAIL serr_payload_1 got=%0h exp=0", payload_1); else passed++;
        idle_phase();
        tick();
        total++; if (err_status !== 2'b00) $display("FAIL serr_cleared got=%0h exp=0", err_status); else passed++;
    endtask

    task automatic test_status_collision();
        addr_phase(2'd2, 8'h00, 1'b0, 3'd0);
        tick();
        addr_phase(2'd2, 8'h00, 1'b1, 3'd0);
        tick();
        total++; if (err_status !== 2'b11) $display("FAIL coll_err_status got=%0h exp=3", err_status); else passed++;
        total++; if (hready_fe !== 1'b0) $display("FAIL coll_hready_fe got=%0b exp=0", hready_fe); else passed++;
        idle_phase();
        tick();
        tick();
    endtask

    task automatic test_back_to_back();
        addr_phase(2'd2, 8'h01, 1'b1, 3'd0);
        tick();
        hwdata = 8'h11;
        addr_phase(2'd3, 8'h02, 1'b1, 3'd0);
        tick();
        total++; if (payload_0 !== 8'h11) $display("FAIL b2b_payload_0 got=%0h exp=11", payload_0); else passed++;
        total++; if (hready_fe !== 1'b1) $display("FAIL b2b_hready_fe_1 got=%0b exp=1", hready_fe); else passed++;
        hwdata = 8'h22;
        addr_phase(2'd3, 8'h03, 1'b1, 3'd0);
        tick();
        total++; if (payload_1 !== 8'h22) $display("FAIL b2b_payload_1 got=%0h exp=22", payload_1); else passed++;
        total++; if (hready_fe !== 1'b1) $display("FAIL b2b_hready_fe_2 got=%0b exp=1", hready_fe); else passed++;
        hwdata = 8'hE5;
        addr_phase(2'd2, 8'h00, 1'b0, 3'd0);
        tick();
        total++; if (data_size !== 5'h05) $display("FAIL b2b_data_size got=%0h exp=5", data_size); else passed++;
        total++; if (err_status !== 2'b11) $display("FAIL b2b_err_held got=%0h exp=3", err_status); else passed++;
        total++; if (read_select !== 2'd0) $display("FAIL b2b_read_select got=%0h exp=0", read_select); else passed++;
        idle_phase();
        tick();
        total++; if (err_status !== 2'b00) $display("FAIL b2b_err_cleared got=%0h exp=0", err_status); else passed++;
        total++; if (payload_0 !== 8'h11) $display("FAIL b2b_read_no_write got=%0h exp=11", payload_0); else passed++;
    endtask

    task automatic test_busy_idle();
        hwdata = 8'hEE;
        addr_phase(2'd1, 8'h11, 1'b1, 3'd1);
        tick();
        total++; if (current_hresp !== 1'b0) $display("FAIL busy_hresp got=%0b exp=0", current_hresp); else passed++;
        total++; if (hready_fe !== 1'b1) $display("FAIL busy_hready_fe got=%0b exp=1", hready_fe); else passed++;
        addr_phase(2'd0, 8'h01, 1'b1, 3'd0);
        tick();
        tick();
        total++; if (payload_0 !== 8'h11) $display("FAIL busy_payload_0 got=%0h exp=11", payload_0); else passed++;
        total++; if (err_status !== 2'b00) $display("FAIL busy_err_status got=%0h exp=0", err_status); else passed++;
        total++; if (read_select !== 2'd0) $display("FAIL busy_read_select got=%0h exp=0", read_select); else passed++;
        idle_phase();
    endtask

    task automatic test_reset_in_err1();
        addr_phase(2'd2, 8'h00, 1'b1, 3'd0);
        tick();
        total++; if (hready_fe !== 1'b0) $display("FAIL rerr_in_err1 got=%0b exp=0", hready_fe); else passed++;
        hwdata = 8'h99;
        idle_phase();
        #2;
        hreset_n = 1'b0;
        #1;
        total++; if (current_hresp !== 1'b0) $display("FAIL rerr_hresp got=%0b exp=0", current_hresp); else passed++;
        total++; if (hready_fe !== 1'b1) $display("FAIL rerr_hready_fe got=%0b exp=1", hready_fe); else passed++;
        total++; if (err_status !== 2'b00) $display("FAIL rerr_err_status got=%0h exp=0", err_status); else passed++;
        total++; if (payload_0 !== 8'h00) $display("FAIL rerr_payload_0 got=%0h exp=0", payload_0); else passed++;
        total++; if (payload_1 !== 8'h00) $display("FAIL rerr_payload_1 got=%0h exp=0", payload_1); else passed++;
        total++; if (data_size !== 5'h00) $display("FAIL rerr_data_size got=%0h exp=0", data_size); else passed++;
        total++; if (read_select !== 2'd0) $display("FAIL rerr_read_select got=%0h exp=0", read_select); else passed++;
        @(negedge hclk);
        hreset_n = 1'b1;
        tick();
        addr_phase(2'd2, 8'h02, 1'b1, 3'd0);
        tick();
        total++; if (current_hresp !== 1'b0) $display("FAIL rerr_post_hresp got=%0b exp=0", current_hresp); else passed++;
        total++; if (read_select !== 2'd2) $display("FAIL rerr_post_select got=%0h exp=2", read_select); else passed++;
        hwdata = 8'h77;
        idle_phase();
        tick();
        total++; if (payload_1 !== 8'h77) $display("FAIL rerr_post_payload_1 got=%0h exp=77", payload_1); else passed++;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached after %0d checks", total);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_write_payload0();
        test_size_reg();
        test_addr_error();
        test_size_err_then_status_read();
        test_status_collision();
        test_back_to_back();
        test_busy_idle();
        test_reset_in_err1();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/ahb_slave_frontend.md
AHB_SLAVE_FRONTEND -- requirements
Module: ahb_slave_frontend

Interface
REQ-001 Parameter: ADDR_W, default 8, HADDR width; SHALL be at least 3.
REQ-002 Clock and reset SHALL be one clock and an asynchronous, active-low reset: hclk (rising edge) and hreset_n.
REQ-003 Ports: hclk  in  1  system clock.
REQ-004 Ports: hreset_n  in  1  asynchronous active-low reset.
REQ-005 Ports: hsel_x  in  1  slave select.
REQ-006 Ports: haddr  in  ADDR_W  address-phase address.
REQ-007 Ports: htrans  in  2  transfer type (IDLE=0, BUSY=1, NONSEQ=2, SEQ=3).
REQ-008 Ports: hwrite  in  1  write direction.
REQ-009 Ports: hsize  in  3  transfer size.
REQ-010 Ports: hwdata  in  8  write data.
REQ-011 Ports: hready  in  1  bus ready.
REQ-012 Ports: read_select  out  2  registered register index for the read stage.
REQ-013 Ports: err_status  out  2  sticky last-error code.
REQ-014 Ports: payload_0  out  8  payload register 0.
REQ-015 Ports: payload_1  out  8  payload register 1.
REQ-016 Ports: data_size  out  5  size register.
REQ-017 Ports: current_hresp  out  1  response for the current data phase (1=ERROR).
REQ-018 Ports: hready_fe  out  1  frontend ready contribution (0 inserts a wait state).

Function
REQ-019 A transfer SHALL be accepted when hsel_x && hready && htrans[1] are all high at a rising edge.
REQ-020 On acceptance, the block SHALL register haddr[1:0], hwrite and an error code in the same cycle.
REQ-021 read_select SHALL equal the accepted haddr[1:0] from the cycle after acceptance.
REQ-022 Register map: 0 = status (read-only); 1 = payload_0; 2 = payload_1; 3 = data_size, using hwdata[4:0].
REQ-023 Error codes SHALL be assigned in this priority order: 01 when haddr[ADDR_W-1:2] != 0; 10 when hsize != 0; 11 for a write to address 0; 00 otherwise.
REQ-024 FSM states SHALL be IDLE, DATA, ERR1 and ERR2.
REQ-025 A clean accept SHALL move the FSM to DATA; an error accept SHALL move it to ERR1; no accept SHALL move it to IDLE.
REQ-026 In DATA: current_hresp=0 and hready_fe=1; the next state is chosen by the acceptance rule in REQ-025.
REQ-027 In ERR1: current_hresp=1 and hready_fe=0; the FSM SHALL go unconditionally to ERR2.
REQ-028 In ERR2: current_hresp=1 and hready_fe=1; the next state is chosen by the acceptance rule in REQ-025.
REQ-029 No transfer SHALL be accepted while in ERR1, because hready is low on the bus.
REQ-030 Write data SHALL be captured from hwdata at the end of a DATA-state write, i.e. at the edge where the FSM leaves DATA, into the addressed register.
REQ-031 Errored writes SHALL NOT modify any register.
REQ-032 err_status SHALL load the nonzero error code on an error accept and hold it; a new error SHALL overwrite it.
REQ-033 A completed clean read of address 0 SHALL clear err_status at the end of its DATA phase.
REQ-034 If a status read completes at the same edge as a new error accept, the new error code SHALL win.
REQ-035 htrans BUSY or IDLE with hsel_x high SHALL give a zero-wait OKAY response and no register change.
REQ-036 Back-to-back accepts in consecutive DATA cycles SHALL be supported with no bubble.

Reset
REQ-037 Assertion of hreset_n SHALL take effect immediately, without a clock edge.
REQ-038 Reset values: state IDLE; read_select, err_status, payload_0, payload_1 and data_size 0; current_hresp 0; hready_fe 1.
REQ-039 Reset asserted mid-transfer, including in ERR1 or ERR2, SHALL abort the transfer with no register write.

Structure
REQ-040 The shared package ahb_pkg SHALL hold: htrans_e enum, frontend FSM state enum, register index constants, and error code constants.
REQ-041 The implementation SHALL be a single module; the register bank MAY be split into sub-module ahb_reg_bank (write port plus three registers).

Verification
REQ-042 Write 0xA5 to address 1, hsize=0 -> OKAY, zero wait; payload_0=0xA5 on the next cycle.
REQ-043 Read address 3 after writing 0x1F -> read_select=3, data_size=0x1F, current_hresp=0.
REQ-044 Access haddr=0x10 -> ERR1 (current_hresp=1, hready_fe=0) then ERR2 (current_hresp=1, hready_fe=1); err_status=01; no register change.
REQ-045 Write hsize=1 to address 2, then read address 0 -> err_status=10 during the read; 00 after the DATA phase completes.
REQ-046 Status read completing at the same edge as a write to address 0 is accepted -> err_status=11.
REQ-047 Assert hreset_n low during ERR1 -> all outputs at reset values immediately; the next transfer is accepted normally.
